// File: rtl/jtag_tap_driver.sv
// -----------------------------------------------------------------------------
// jtag_tap_driver
//
// JTAG test-port initiator. It walks the target TAP to Run-Test/Idle after
// reset. On each accepted start it performs one IR scan followed by one DR scan
// and returns the DR bits shifted out of the target. The internal state tracks
// the target TAP state cycle by cycle, so TMS/TDI are a plain decode of it.
//
// Parameters
//   IR_LEN  instruction register length (>= 1)
//   DR_LEN  selected data register length (>= 1)
//
// Ports
//   TCLK    in   test clock, all state changes on posedge
//   TRESET  in   asynchronous active-high reset
//   start   in   transaction request, only honoured in IDLE
//   ir_in   in   opcode, shifted LSB first
//   dr_in   in   data word, shifted LSB first
//   TDO     in   target serial output
//   TMS     out  TAP mode select
//   TDI     out  serial data to target
//   busy    out  high in every state except IDLE
//   done    out  one-cycle completion pulse (first IDLE cycle)
//   dr_out  out  captured DR word, held until the next done
// -----------------------------------------------------------------------------
module jtag_tap_driver #(
    parameter int IR_LEN = 4,
    parameter int DR_LEN = 17
) (
    input  logic              TCLK,
    input  logic              TRESET,
    input  logic              start,
    input  logic [IR_LEN-1:0] ir_in,
    input  logic [DR_LEN-1:0] dr_in,
    input  logic              TDO,
    output logic              TMS,
    output logic              TDI,
    output logic              busy,
    output logic              done,
    output logic [DR_LEN-1:0] dr_out
);

    localparam int MAX_LEN = (IR_LEN > DR_LEN) ? IR_LEN : DR_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] IR_LAST   = CNT_W'(IR_LEN - 1);
    localparam logic [CNT_W-1:0] DR_LAST   = CNT_W'(DR_LEN - 1);
    localparam logic [2:0]       WALK_LAST = 3'd4;  // five TMS=1 cycles

    // Each state equals the target TAP state during the same cycle.
    localparam logic [3:0] S_WALK    = 4'd0;
    localparam logic [3:0] S_SETTLE  = 4'd1;
    localparam logic [3:0] S_IDLE    = 4'd2;
    localparam logic [3:0] S_SEL_DR1 = 4'd3;
    localparam logic [3:0] S_SEL_IR  = 4'd4;
    localparam logic [3:0] S_CAP_IR  = 4'd5;
    localparam logic [3:0] S_SH_IR   = 4'd6;
    localparam logic [3:0] S_EX1_IR  = 4'd7;
    localparam logic [3:0] S_UPD_IR  = 4'd8;
    localparam logic [3:0] S_SEL_DR2 = 4'd9;
    localparam logic [3:0] S_CAP_DR  = 4'd10;
    localparam logic [3:0] S_SH_DR   = 4'd11;
    localparam logic [3:0] S_EX1_DR  = 4'd12;
    localparam logic [3:0] S_UPD_DR  = 4'd13;

    logic [3:0]        state;
    logic [3:0]        state_next;
    logic [2:0]        walk_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IR_LEN-1:0] ir_shift;
    logic [DR_LEN-1:0] dr_shift;
    logic [DR_LEN-1:0] cap_reg;
    logic [DR_LEN-1:0] cap_next;
    logic              ir_last;
    logic              dr_last;
    logic              accept;

    assign ir_last = (bit_cnt == IR_LAST);
    assign dr_last = (bit_cnt == DR_LAST);
    assign accept  = (state == S_IDLE) && start;
    assign busy    = (state != S_IDLE);

    // Newest TDO bit enters at the MSB, so the first bit out of the target
    // ends up in bit 0 once all DR_LEN bits have been taken.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        cap_next           = cap_reg >> 1;
        cap_next[DR_LEN-1] = TDO;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_WALK:    if (walk_cnt == WALK_LAST) state_next = S_SETTLE;
            S_SETTLE:  state_next = S_IDLE;
            S_IDLE:    if (start) state_next = S_SEL_DR1;
            S_SEL_DR1: state_next = S_SEL_IR;
            S_SEL_IR:  state_next = S_CAP_IR;
            S_CAP_IR:  state_next = S_SH_IR;
            S_SH_IR:   if (ir_last) state_next = S_EX1_IR;
            S_EX1_IR:  state_next = S_UPD_IR;
            S_UPD_IR:  state_next = S_SEL_DR2;
            S_SEL_DR2: state_next = S_CAP_DR;
            S_CAP_DR:  state_next = S_SH_DR;
            S_SH_DR:   if (dr_last) state_next = S_EX1_DR;
            S_EX1_DR:  state_next = S_UPD_DR;
            S_UPD_DR:  state_next = S_IDLE;
            default:   state_next = S_WALK;
        endcase
    end

    // TMS is the value that moves the target into state_next at the coming
    // posedge. Only IDLE depends on an input (start), so TMS is otherwise
    // stable for the whole cycle.
    always_comb begin
        TMS = 1'b1;
        case (state)
            S_WALK:    TMS = 1'b1;
            S_SETTLE:  TMS = 1'b0;
            S_IDLE:    TMS = start;
            S_SEL_DR1: TMS = 1'b1;
            S_SEL_IR:  TMS = 1'b0;
            S_CAP_IR:  TMS = 1'b0;
            S_SH_IR:   TMS = ir_last;
            S_EX1_IR:  TMS = 1'b1;
            S_UPD_IR:  TMS = 1'b1;
            S_SEL_DR2: TMS = 1'b0;
            S_CAP_DR:  TMS = 1'b0;
            S_SH_DR:   TMS = dr_last;
            S_EX1_DR:  TMS = 1'b1;
            S_UPD_DR:  TMS = 1'b0;
            default:   TMS = 1'b1;
        endcase
    end

    always_comb begin
        TDI = 1'b0;
        if (state == S_SH_IR) TDI = ir_shift[0];
        if (state == S_SH_DR) TDI = dr_shift[0];
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of the others, matching the hardware.
    always_ff @(posedge TCLK or posedge TRESET) begin
        if (TRESET) begin
            state    <= S_WALK;
            walk_cnt <= '0;
            bit_cnt  <= '0;
            // NOTE: the shift and capture registers are reset as well; they
            // are small flop banks, not RAM, and a known value keeps TDI clean.
            ir_shift <= '0;
            dr_shift <= '0;
            cap_reg  <= '0;
            dr_out   <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_next;

            if (state == S_WALK) walk_cnt <= walk_cnt + 3'd1;
            else                 walk_cnt <= '0;

            // Counter restarts on entry to each shift state, so it never wraps.
            if (state == S_CAP_IR || state == S_CAP_DR)
                bit_cnt <= '0;
            else if (state == S_SH_IR || state == S_SH_DR)
                bit_cnt <= bit_cnt + CNT_W'(1);

            if (accept) begin
                ir_shift <= ir_in;
                dr_shift <= dr_in;
            end else begin
                if (state == S_SH_IR) ir_shift <= ir_shift >> 1;
                if (state == S_SH_DR) dr_shift <= dr_shift >> 1;
            end

            if (state == S_SH_DR) cap_reg <= cap_next;

            if (state == S_UPD_DR) dr_out <= cap_reg;
            done <= (state == S_UPD_DR);
        end
    end

endmodule

// File: tb/tb_jtag_tap_driver.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_driver
//
// Drives jtag_tap_driver (IR_LEN=4, DR_LEN=17) against a behavioural 16-state
// target TAP with a 4-bit IR and a 17-bit TDR whose capture value is its own
// parallel register. A second DUT instance (IR_LEN=1, DR_LEN=1) sees a
// constant TDO. Inputs change at negedge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_jtag_tap_driver;

    logic        TCLK = 1'b0;
    logic        TRESET;
    logic        start;
    logic [3:0]  ir_in;
    logic [16:0] dr_in;
    logic        TDO;
    logic        TMS, TDI, busy, done;
    logic [16:0] dr_out;

    logic        s_start, s_tdo, s_tms, s_tdi, s_busy, s_done;
    logic [0:0]  s_ir_in, s_dr_in, s_dr_out;

    int errors = 0;
    int checks = 0;

    always #5 TCLK = ~TCLK;

    jtag_tap_driver #(.IR_LEN(4), .DR_LEN(17)) u_dut (
        .TCLK(TCLK), .TRESET(TRESET), .start(start), .ir_in(ir_in),
        .dr_in(dr_in), .TDO(TDO), .TMS(TMS), .TDI(TDI), .busy(busy),
        .done(done), .dr_out(dr_out)
    );

    jtag_tap_driver #(.IR_LEN(1), .DR_LEN(1)) u_small (
        .TCLK(TCLK), .TRESET(TRESET), .start(s_start), .ir_in(s_ir_in),
        .dr_in(s_dr_in), .TDO(s_tdo), .TMS(s_tms), .TDI(s_tdi), .busy(s_busy),
        .done(s_done), .dr_out(s_dr_out)
    );

    // ---------------- target TAP model ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
        SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
    } tap_t;

    tap_t        m_state;
    logic [3:0]  m_ir_sh, m_ir;
    logic [16:0] m_dr_sh, m_dr_par;
    logic        preload_en = 1'b0;
    logic [16:0] preload_val = '0;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TLR:  return tms ? TLR  : RTI;
            RTI:  return tms ? SDR  : RTI;
            SDR:  return tms ? SIR  : CDR;
            CDR:  return tms ? E1DR : SHDR;
            SHDR: return tms ? E1DR : SHDR;
            E1DR: return tms ? UDR  : PDR;
            PDR:  return tms ? E2DR : PDR;
            E2DR: return tms ? UDR  : SHDR;
            UDR:  return tms ? SDR  : RTI;
            SIR:  return tms ? TLR  : CIR;
            CIR:  return tms ? E1IR : SHIR;
            SHIR: return tms ? E1IR : SHIR;
            E1IR: return tms ? UIR  : PIR;
            PIR:  return tms ? E2IR : PIR;
            E2IR: return tms ? UIR  : SHIR;
            default: return tms ? SDR : RTI;  // UIR
        endcase
    endfunction

    // TRESET doubles as the target's TRST; it does not clear the TDR.
    always @(posedge TCLK or posedge TRESET) begin
        if (TRESET) begin
            m_state <= TLR;
        end else begin
            m_state <= tap_next(m_state, TMS);
            case (m_state)
                CIR:  m_ir_sh  <= 4'b0001;
                SHIR: m_ir_sh  <= {TDI, m_ir_sh[3:1]};
                UIR:  m_ir     <= m_ir_sh;
                CDR:  m_dr_sh  <= m_dr_par;
                SHDR: m_dr_sh  <= {TDI, m_dr_sh[16:1]};
                UDR:  m_dr_par <= m_dr_sh;
                default: ;
            endcase
            if (preload_en) m_dr_par <= preload_val;
        end
    end

    assign TDO = (m_state == SHDR) ? m_dr_sh[0] :
                 (m_state == SHIR) ? m_ir_sh[0] : 1'b0;

    // ---------------- capture logs ----------------
    logic        tms_log  [0:79];
    logic        tdi_log  [0:79];
    logic        busy_log [0:79];
    logic        done_log [0:79];
    logic [16:0] out_log  [0:79];

    // Cycle 0 is the start cycle (DUT must be in IDLE). Extra start pulses at
    // pa/pb; TRESET raised at rst_at and released two cycles later.
    task automatic run_capture(input int n, input int pa, input int pb, input int rst_at);
        for (int k = 0; k < n; k++) begin
            @(negedge TCLK);
            start = (k == 0) || (k == pa) || (k == pb);
            if (k == rst_at) TRESET = 1'b1;
            if (rst_at >= 0 && k == rst_at + 2) TRESET = 1'b0;
            #1;
            tms_log[k]  = TMS;
            tdi_log[k]  = TDI;
            busy_log[k] = busy;
            done_log[k] = done;
            out_log[k]  = dr_out;
        end
        start = 1'b0;
    endtask

    task automatic preload(input logic [16:0] v);
        @(negedge TCLK);
        preload_val = v;
        preload_en  = 1'b1;
        @(negedge TCLK);
        preload_en  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge TCLK);
        @(negedge TCLK);
        #1;
        checks++; if (TMS !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || dr_out !== 17'h0) begin
            errors++; $display("FAIL reset_hold: TMS=%b busy=%b done=%b dr_out=%h want 1 1 0 00000", TMS, busy, done, dr_out);
        end
        @(negedge TCLK);
        TRESET = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge TCLK);
            #1;
            checks++; if (TMS !== (k < 5)) begin
                errors++; $display("FAIL reset_tms[%0d]: got %b want %b", k, TMS, (k < 5));
            end
            checks++; if (busy !== (k < 6)) begin
                errors++; $display("FAIL reset_busy[%0d]: got %b want %b", k, busy, (k < 6));
            end
            checks++; if (done !== 1'b0 || dr_out !== 17'h0) begin
                errors++; $display("FAIL reset_out[%0d]: done=%b dr_out=%h want 0 00000", k, done, dr_out);
            end
        end
    endtask

    task automatic test_single();
        logic exp_tms [0:31];
        logic exp_tdi [0:3];
        exp_tdi = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 32; k++) exp_tms[k] = 1'b0;
        exp_tms[0] = 1; exp_tms[1] = 1; exp_tms[7] = 1; exp_tms[8] = 1;
        exp_tms[9] = 1; exp_tms[28] = 1; exp_tms[29] = 1;
        preload(17'h1C0DE);
        ir_in = 4'hA;
        dr_in = 17'h12345;
        run_capture(33, -1, -1, -1);
        ir_in = 4'h0;
        dr_in = 17'h0;
        for (int k = 0; k < 32; k++) begin
            checks++; if (tms_log[k] !== exp_tms[k]) begin
                errors++; $display("FAIL single_tms[%0d]: got %b want %b", k, tms_log[k], exp_tms[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (tdi_log[4+k] !== exp_tdi[k]) begin
                errors++; $display("FAIL single_tdi_ir[%0d]: got %b want %b", k, tdi_log[4+k], exp_tdi[k]);
            end
        end
        checks++; if (tdi_log[0] !== 1'b0 || tdi_log[9] !== 1'b0 || tdi_log[30] !== 1'b0) begin
            errors++; $display("FAIL single_tdi_idle: got %b%b%b want 000", tdi_log[0], tdi_log[9], tdi_log[30]);
        end
        for (int k = 0; k < 33; k++) begin
            checks++; if (busy_log[k] !== (k >= 1 && k <= 30) || done_log[k] !== (k == 31)) begin
                errors++; $display("FAIL single_busy_done[%0d]: busy=%b done=%b", k, busy_log[k], done_log[k]);
            end
        end
        checks++; if (m_dr_par !== 17'h12345) begin
            errors++; $display("FAIL single_tdr: got %h want 12345", m_dr_par);
        end
        checks++; if (m_ir !== 4'hA) begin
            errors++; $display("FAIL single_ir: got %h want a", m_ir);
        end
        checks++; if (out_log[30] !== 17'h0 || out_log[31] !== 17'h1C0DE) begin
            errors++; $display("FAIL single_dr_out: got %h/%h want 00000/1c0de", out_log[30], out_log[31]);
        end
    endtask

    task automatic test_readback();
        preload(17'h0BEEF);
        dr_in = 17'h0;
        run_capture(33, -1, -1, -1);
        checks++; if (done_log[31] !== 1'b1 || out_log[31] !== 17'h0BEEF) begin
            errors++; $display("FAIL readback1: done=%b dr_out=%h want 1 0beef", done_log[31], out_log[31]);
        end
        dr_in = 17'h1FFFF;
        run_capture(33, -1, -1, -1);
        checks++; if (out_log[30] !== 17'h0BEEF || out_log[31] !== 17'h00000) begin
            errors++; $display("FAIL readback2: got %h/%h want 0beef/00000", out_log[30], out_log[31]);
        end
        checks++; if (m_dr_par !== 17'h1FFFF) begin
            errors++; $display("FAIL readback2_tdr: got %h want 1ffff", m_dr_par);
        end
    endtask

    task automatic test_start_ignored();
        int n_done;
        dr_in = 17'h0F0F0;
        run_capture(40, 5, 20, -1);
        n_done = 0;
        for (int k = 0; k < 40; k++) if (done_log[k] === 1'b1) n_done++;
        checks++; if (n_done !== 1 || done_log[31] !== 1'b1) begin
            errors++; $display("FAIL ignored_done: count=%0d done31=%b want 1 1", n_done, done_log[31]);
        end
        checks++; if (tms_log[5] !== 1'b0 || tms_log[20] !== 1'b0) begin
            errors++; $display("FAIL ignored_tms: got %b%b want 00", tms_log[5], tms_log[20]);
        end
        checks++; if (busy_log[30] !== 1'b1 || busy_log[32] !== 1'b0 || busy_log[39] !== 1'b0) begin
            errors++; $display("FAIL ignored_busy: got %b%b%b want 100", busy_log[30], busy_log[32], busy_log[39]);
        end
        checks++; if (out_log[31] !== 17'h1FFFF) begin
            errors++; $display("FAIL ignored_dr_out: got %h want 1ffff", out_log[31]);
        end
    endtask

    task automatic test_back_to_back();
        dr_in = 17'h0AAAA;
        run_capture(64, 31, -1, -1);
        checks++; if (done_log[31] !== 1'b1 || tms_log[31] !== 1'b1) begin
            errors++; $display("FAIL b2b_start: done=%b TMS=%b want 1 1", done_log[31], tms_log[31]);
        end
        for (int k = 32; k < 64; k++) begin
            checks++; if (busy_log[k] !== (k <= 61) || done_log[k] !== (k == 62)) begin
                errors++; $display("FAIL b2b_busy_done[%0d]: busy=%b done=%b", k, busy_log[k], done_log[k]);
            end
        end
        checks++; if (out_log[31] !== 17'h0F0F0 || out_log[61] !== 17'h0F0F0 || out_log[62] !== 17'h0AAAA) begin
            errors++; $display("FAIL b2b_dr_out: got %h/%h/%h want 0f0f0/0f0f0/0aaaa", out_log[31], out_log[61], out_log[62]);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] par_before;
        par_before = m_dr_par;
        dr_in = 17'h00ABC;
        run_capture(60, -1, -1, 20);
        checks++; if (tms_log[19] !== 1'b0 || busy_log[19] !== 1'b1 || out_log[19] !== 17'h0AAAA) begin
            errors++; $display("FAIL mid_pre: TMS=%b busy=%b dr_out=%h want 0 1 0aaaa", tms_log[19], busy_log[19], out_log[19]);
        end
        checks++; if (tms_log[20] !== 1'b1 || busy_log[20] !== 1'b1 || done_log[20] !== 1'b0 || out_log[20] !== 17'h0) begin
            errors++; $display("FAIL mid_reset: TMS=%b busy=%b done=%b dr_out=%h want 1 1 0 00000", tms_log[20], busy_log[20], done_log[20], out_log[20]);
        end
        for (int k = 0; k < 60; k++) begin
            checks++; if (done_log[k] !== 1'b0) begin
                errors++; $display("FAIL mid_no_done[%0d]: got %b want 0", k, done_log[k]);
            end
        end
        checks++; if (busy_log[27] !== 1'b1 || tms_log[27] !== 1'b0 || busy_log[28] !== 1'b0) begin
            errors++; $display("FAIL mid_rewalk: busy27=%b tms27=%b busy28=%b want 1 0 0", busy_log[27], tms_log[27], busy_log[28]);
        end
        checks++; if (m_dr_par !== par_before) begin
            errors++; $display("FAIL mid_tdr: got %h want %h", m_dr_par, par_before);
        end
    endtask

    task automatic test_small();
        int waited;
        waited = 0;
        while (s_busy !== 1'b0 && waited < 20) begin
            @(negedge TCLK);
            waited++;
        end
        checks++; if (s_busy !== 1'b0) begin
            errors++; $display("FAIL small_idle_timeout: busy=%b want 0", s_busy);
        end
        s_tdo = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge TCLK);
            s_start = (k == 0);
            #1;
            checks++; if (s_busy !== (k >= 1 && k <= 11) || s_done !== (k == 12)) begin
                errors++; $display("FAIL small_busy_done[%0d]: busy=%b done=%b", k, s_busy, s_done);
            end
            if (k == 11 || k == 12) begin
                checks++; if (s_dr_out !== ((k == 12) ? 1'b1 : 1'b0)) begin
                    errors++; $display("FAIL small_dr_out[%0d]: got %b want %b", k, s_dr_out, (k == 12));
                end
            end
        end
        s_start = 1'b0;
    endtask

    initial begin
        TRESET  = 1'b1;
        start   = 1'b0;
        ir_in   = '0;
        dr_in   = '0;
        s_start = 1'b0;
        s_tdo   = 1'b0;
        s_ir_in = 1'b1;
        s_dr_in = 1'b0;
        test_reset();
        test_single();
        test_readback();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
